alu_req_sequencer: RTL and testbench
====================================

Name: alu_req_sequencer

Overview:
- Two-requester front end for the 16-bit non-reversible ALU (add / subtract / multiply / shift).
- Round-robin arbitration selects one request at a time.
- The winning request's operands and sel code are registered and held on the ALU inputs for a programmable settle time.
- The selected 32-bit result is captured and returned to the winning requester over a valid/ready response channel.

Parameters:
- SETTLE_CYCLES, 2, cycles operands are held on the ALU before the result is captured; legal range 1..15.
- CNT_W, 4, width of the settle counter; must hold SETTLE_CYCLES.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester request valid (bit i = requester i).
- req_ready  out  2  per-requester accept strobe.
- req_op  in  4  {op1,op0}; per requester 2'b00 add, 01 sub, 10 mul, 11 shift.
- req_a  in  32  {a1,a0}, 16-bit operand A per requester.
- req_b  in  32  {b1,b0}, 16-bit operand B per requester.
- req_cin  in  2  carry-in per requester, used by add only.
- rsp_valid  out  2  per-requester response valid.
- rsp_ready  in  2  per-requester response accept.
- rsp_data  out  32  result, shared bus; meaningful only where rsp_valid=1.
- alu_sel  out  2  ALU operation select.
- alu_x  out  16  ALU operand X.
- alu_y  out  16  ALU operand Y.
- alu_cin  out  1  ALU carry-in.
- alu_sum  in  17  ALU adder result.
- alu_diff  in  16  ALU subtract result (Y minus X).
- alu_m  in  32  ALU product.
- alu_lsh  in  16  ALU left-shift result.
- alu_rsh  in  16  ALU right-shift result.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Clock and reset: one clock clk; rst_n is asynchronous, active-low.
- Reset values: state=IDLE; rsp_valid=0; req_ready=0; rsp_data=0; alu_sel=0; alu_x=0; alu_y=0; alu_cin=0; busy=0; last_grant=1, so requester 0 wins first.
- Reset asserted mid-operation: the in-flight request and any pending response are discarded with no rsp_valid. Requesters must re-issue.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is set, grant round-robin: prefer the requester that is not last_grant.
  - req_ready[g] is asserted combinationally, for the grantee only, in the same cycle.
  - On that edge: latch op, A, B and cin; set last_grant=g; go to ISSUE.
  - No valid requests: remain in IDLE with req_ready=0.
- ISSUE (1 cycle):
  - Drive alu_sel=op and load the counter with SETTLE_CYCLES-1.
  - Operand mapping for add, mul and shift: X=A, Y=B. For shift, B is the shift amount, passed unclamped; amounts ≥16 yield 0 from the datapath.
  - Operand mapping for sub: X=B, Y=A, so the datapath returns A−B.
  - alu_cin=cin for add, 0 otherwise.
  - Go to WAIT.
- WAIT: decrement the counter each cycle; operands and alu_sel are held stable. When the count reaches 0, capture rsp_data and go to RESP.
- Captured result by op:
  - add: {15'b0, alu_sum}.
  - sub: {16'b0, alu_diff}.
  - mul: alu_m.
  - shift: {alu_lsh, alu_rsh}.
- RESP:
  - rsp_valid[g]=1; rsp_data is held stable.
  - When rsp_ready[g]=1: clear rsp_valid and go to IDLE. A new grant is possible on the next cycle.
  - Backpressure is unbounded; a stalled response blocks both requesters.
- Latency: the accept edge to rsp_valid rising is SETTLE_CYCLES+1 cycles. Minimum spacing of back-to-back requests is SETTLE_CYCLES+3 cycles.
- Simultaneous valid on both requesters: strict alternation, starting with requester 0 after reset.
- A requester deasserting req_valid without a grant is legal; it is not sampled.
- Requests arriving while busy are ignored until IDLE.
- Arithmetic is modulo 2^16 except add (17-bit) and mul (32-bit).

Decomposition:
- Shared package:
  - op encodings: OP_ADD, OP_SUB, OP_MUL, OP_SHF.
  - state encoding constants.
  - result-width constants: 16 / 17 / 32.
- One natural sub-module, rr_arbiter2: a 2-way round-robin grant with a last_grant register.
- The FSM, operand mapping and result mux stay in the top.

Test Plan:
- Add: req0 op=00, A=0xFFFF, B=0x0001, cin=0 -> rsp_valid[0] exactly 3 cycles after accept with SETTLE_CYCLES=2; rsp_data=0x0001_0000.
- Sub and mul:
  - req1 op=01, A=0x0005, B=0x0007 -> rsp_data=0x0000_FFFE.
  - op=10, A=0x0100, B=0x0100 -> rsp_data=0x0001_0000.
- Shift: op=11, A=0x8001, B=0x0004 -> rsp_data=0x0010_0800. B=0x0014 -> rsp_data=0x0000_0000.
- Both req_valid held high for 4 transactions -> grants alternate 0,1,0,1. Each req_ready is a one-cycle pulse; responses route to the matching rsp_valid bit.
- Response backpressure: rsp_ready held 0 for 10 cycles -> rsp_valid and rsp_data stay stable and busy=1. The other requester's req_ready stays 0 until the response is accepted.
- Reset mid-WAIT: rst_n pulsed low asynchronously -> all outputs return to reset values with no clock edge. No response is issued, and the next grant goes to requester 0.

Source files
------------

// File: rtl/alu_req_sequencer_pkg.sv
// Shared definitions for the two-requester ALU front end: operation codes,
// FSM state encodings and datapath result widths.
package alu_req_sequencer_pkg;

    // ALU operation select codes
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_SHF = 2'b11;

    // Sequencer FSM states
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ISSUE = 2'b01;
    localparam logic [1:0] ST_WAIT  = 2'b10;
    localparam logic [1:0] ST_RESP  = 2'b11;

    // Datapath result widths
    localparam int unsigned W_NARROW = 16;
    localparam int unsigned W_ADD    = 17;
    localparam int unsigned W_MUL    = 32;

endpackage

// File: rtl/alu_req_sequencer_arb.sv
// Two-way round-robin arbiter. When both requests are present, the requester
// that did not win last time is granted. last_grant updates only when the
// grant is actually consumed (advance).
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       grant_idx,
    output logic       last_grant
);

    // Pick the winner from the current requests and the previous winner
    always_comb begin
        grant_idx = 1'b0;
        if (req == 2'b11) begin
            grant_idx = ~last_grant;
        end else if (req[1]) begin
            grant_idx = 1'b1;
        end
        grant = '0;
        if (req != 2'b00) begin
            grant = grant_idx ? 2'b10 : 2'b01;
        end
    end

    // Remember the last consumed grant; reset value makes requester 0 win first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (advance) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/alu_req_sequencer.sv
// Two-requester front end for the 16-bit ALU. A round-robin winner's operands
// are registered onto the ALU inputs, held for SETTLE_CYCLES, and the selected
// result is returned to that requester over a valid/ready response channel.
module alu_req_sequencer
    import alu_req_sequencer_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [3:0]          req_op,
    input  logic [31:0]         req_a,
    input  logic [31:0]         req_b,
    input  logic [1:0]          req_cin,
    output logic [1:0]          rsp_valid,
    input  logic [1:0]          rsp_ready,
    output logic [31:0]         rsp_data,
    output logic [1:0]          alu_sel,
    output logic [15:0]         alu_x,
    output logic [15:0]         alu_y,
    output logic                alu_cin,
    input  logic [W_ADD-1:0]    alu_sum,
    input  logic [W_NARROW-1:0] alu_diff,
    input  logic [W_MUL-1:0]    alu_m,
    input  logic [W_NARROW-1:0] alu_lsh,
    input  logic [W_NARROW-1:0] alu_rsh,
    output logic                busy
);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       grant;
    logic             grant_idx;
    logic             owner;
    logic             accept;
    logic [1:0]       op_g;
    logic [15:0]      a_g;
    logic [15:0]      b_g;
    logic             cin_g;
    logic [31:0]      result;

    rr_arbiter2 u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req_valid),
        .advance    (accept),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .last_grant (owner)
    );

    // Grant handshake and per-requester operand selection for the winner
    always_comb begin
        accept    = rst_n && (state == ST_IDLE) && (req_valid != 2'b00);
        req_ready = accept ? grant : 2'b00;
        op_g      = grant_idx ? req_op[3:2]  : req_op[1:0];
        a_g       = grant_idx ? req_a[31:16] : req_a[15:0];
        b_g       = grant_idx ? req_b[31:16] : req_b[15:0];
        cin_g     = grant_idx ? req_cin[1]   : req_cin[0];
    end

    // Result selection from the ALU outputs by the held operation
    always_comb begin
        result = '0;
        case (alu_sel)
            OP_ADD:  result = {15'b0, alu_sum};
            OP_SUB:  result = {16'b0, alu_diff};
            OP_MUL:  result = alu_m;
            default: result = {alu_lsh, alu_rsh};
        endcase
    end

    // Response routing and status decoded from the registered state
    always_comb begin
        rsp_valid = 2'b00;
        if (state == ST_RESP) begin
            rsp_valid = owner ? 2'b10 : 2'b01;
        end
        busy = (state != ST_IDLE);
    end

    // Sequencer FSM. Operands are mapped onto the ALU registers directly at the
    // accept edge, so they are already stable while ISSUE loads the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            rsp_data <= '0;
            alu_sel  <= '0;
            alu_x    <= '0;
            alu_y    <= '0;
            alu_cin  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        alu_sel <= op_g;
                        alu_cin <= (op_g == OP_ADD) ? cin_g : 1'b0;
                        if (op_g == OP_SUB) begin
                            alu_x <= b_g;
                            alu_y <= a_g;
                        end else begin
                            alu_x <= a_g;
                            alu_y <= b_g;
                        end
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt   <= CNT_W'(SETTLE_CYCLES - 1);
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        rsp_data <= result;
                        state    <= ST_RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    if (rsp_ready[owner]) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_sequencer.sv
// Directed self-checking bench for alu_req_sequencer with a behavioural ALU.
module tb_alu_req_sequencer;

    localparam int unsigned SETTLE = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [3:0]  req_op = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [1:0]  req_cin = '0;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = '0;
    logic [31:0] rsp_data;
    logic [1:0]  alu_sel;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic        alu_cin;
    logic [16:0] alu_sum;
    logic [15:0] alu_diff;
    logic [31:0] alu_m;
    logic [15:0] alu_lsh;
    logic [15:0] alu_rsh;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Behavioural ALU
    always_comb begin
        alu_sum  = {1'b0, alu_x} + {1'b0, alu_y} + {16'b0, alu_cin};
        alu_diff = alu_y - alu_x;
        alu_m    = {16'b0, alu_x} * {16'b0, alu_y};
        alu_lsh  = (alu_y >= 16'd16) ? 16'h0000 : (alu_x << alu_y[3:0]);
        alu_rsh  = (alu_y >= 16'd16) ? 16'h0000 : (alu_x >> alu_y[3:0]);
    end

    alu_req_sequencer #(.SETTLE_CYCLES(SETTLE), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .alu_sel   (alu_sel),
        .alu_x     (alu_x),
        .alu_y     (alu_y),
        .alu_cin   (alu_cin),
        .alu_sum   (alu_sum),
        .alu_diff  (alu_diff),
        .alu_m     (alu_m),
        .alu_lsh   (alu_lsh),
        .alu_rsh   (alu_rsh),
        .busy      (busy)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
        $fatal(1, "watchdog");
    end

    task automatic set_req(input int idx, input logic [1:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic cin);
        req_op[idx*2 +: 2]  = op;
        req_a[idx*16 +: 16] = a;
        req_b[idx*16 +: 16] = b;
        req_cin[idx]        = cin;
    endtask

    task automatic apply_reset;
        req_valid = '0;
        rsp_ready = '0;
        rst_n     = 1'b0;
        #7;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One full transaction from requester idx alone; caller starts at posedge+1 in IDLE
    task automatic run_txn(input int idx, input logic [1:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic cin,
                           output logic [1:0] ready_seen, output int lat,
                           output logic [31:0] data, output logic [1:0] valid_after);
        set_req(idx, op, a, b, cin);
        req_valid[idx] = 1'b1;
        #1;
        ready_seen = req_ready;
        @(posedge clk);
        #1;
        req_valid[idx] = 1'b0;
        lat = 0;
        while (rsp_valid[idx] !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        data = rsp_data;
        rsp_ready[idx] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[idx] = 1'b0;
        valid_after = rsp_valid;
    endtask

    task automatic test_reset;
        req_valid = 2'b11;
        #3;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
        checks++; if (alu_sel !== 2'b00) begin errors++; $display("FAIL reset_alu_sel: got %b expected 00", alu_sel); end
        checks++; if (alu_x !== 16'h0) begin errors++; $display("FAIL reset_alu_x: got %h expected 0", alu_x); end
        checks++; if (alu_y !== 16'h0) begin errors++; $display("FAIL reset_alu_y: got %h expected 0", alu_y); end
        checks++; if (alu_cin !== 1'b0) begin errors++; $display("FAIL reset_alu_cin: got %b expected 0", alu_cin); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        apply_reset;
    endtask

    task automatic test_add;
        logic [1:0] rdy; int lat; logic [31:0] d; logic [1:0] va;
        run_txn(0, 2'b00, 16'hFFFF, 16'h0001, 1'b0, rdy, lat, d, va);
        checks++; if (rdy !== 2'b01) begin errors++; $display("FAIL add_ready: got %b expected 01", rdy); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL add_latency: got %0d expected 3", lat); end
        checks++; if (d !== 32'h0001_0000) begin errors++; $display("FAIL add_data: got %h expected 00010000", d); end
        checks++; if (va !== 2'b00) begin errors++; $display("FAIL add_valid_clear: got %b expected 00", va); end
        run_txn(0, 2'b00, 16'h1234, 16'h0001, 1'b1, rdy, lat, d, va);
        checks++; if (d !== 32'h0000_1236) begin errors++; $display("FAIL add_cin_data: got %h expected 00001236", d); end
    endtask

    task automatic test_sub_mul;
        logic [1:0] rdy; int lat; logic [31:0] d; logic [1:0] va;
        run_txn(1, 2'b01, 16'h0005, 16'h0007, 1'b1, rdy, lat, d, va);
        checks++; if (rdy !== 2'b10) begin errors++; $display("FAIL sub_ready: got %b expected 10", rdy); end
        checks++; if (d !== 32'h0000_FFFE) begin errors++; $display("FAIL sub_data: got %h expected 0000fffe", d); end
        run_txn(0, 2'b10, 16'h0100, 16'h0100, 1'b0, rdy, lat, d, va);
        checks++; if (d !== 32'h0001_0000) begin errors++; $display("FAIL mul_data: got %h expected 00010000", d); end
        run_txn(1, 2'b10, 16'hFFFF, 16'hFFFF, 1'b0, rdy, lat, d, va);
        checks++; if (d !== 32'hFFFE_0001) begin errors++; $display("FAIL mul_max_data: got %h expected fffe0001", d); end
    endtask

    task automatic test_shift;
        logic [1:0] rdy; int lat; logic [31:0] d; logic [1:0] va;
        run_txn(0, 2'b11, 16'h8001, 16'h0004, 1'b0, rdy, lat, d, va);
        checks++; if (d !== 32'h0010_0800) begin errors++; $display("FAIL shift4_data: got %h expected 00100800", d); end
        run_txn(0, 2'b11, 16'h8001, 16'h0014, 1'b0, rdy, lat, d, va);
        checks++; if (d !== 32'h0000_0000) begin errors++; $display("FAIL shift20_data: got %h expected 00000000", d); end
    endtask

    task automatic test_back_to_back;
        int grants[4];
        int gcount = 0;
        int rcount = 0;
        int pulse_bad = 0;
        int drain = 0;
        logic [1:0] prev = 2'b00;
        logic [1:0] exp_v;
        logic [31:0] exp_d;
        apply_reset;
        set_req(0, 2'b00, 16'd1, 16'd2, 1'b0);
        set_req(1, 2'b10, 16'd3, 16'd4, 1'b0);
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        #1;
        for (int cyc = 0; cyc < 60 && rcount < 4; cyc++) begin
            if (req_ready != 2'b00) begin
                if (prev != 2'b00) pulse_bad++;
                if (gcount < 4) begin
                    grants[gcount] = req_ready[1] ? 1 : 0;
                    gcount++;
                end
            end
            prev = req_ready;
            if (rsp_valid != 2'b00 && rcount < gcount) begin
                exp_v = (grants[rcount] == 1) ? 2'b10 : 2'b01;
                exp_d = (grants[rcount] == 1) ? 32'h0000_000C : 32'h0000_0003;
                checks++; if (rsp_valid !== exp_v) begin errors++; $display("FAIL b2b_rsp_route[%0d]: got %b expected %b", rcount, rsp_valid, exp_v); end
                checks++; if (rsp_data !== exp_d) begin errors++; $display("FAIL b2b_rsp_data[%0d]: got %h expected %h", rcount, rsp_data, exp_d); end
                rcount++;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 2'b00;
        checks++; if (gcount !== 4 || rcount !== 4) begin errors++; $display("FAIL b2b_count: got grants=%0d rsps=%0d expected 4/4", gcount, rcount); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (grants[k] !== (k % 2)) begin errors++; $display("FAIL b2b_grant[%0d]: got %0d expected %0d", k, grants[k], k % 2); end
        end
        checks++; if (pulse_bad !== 0) begin errors++; $display("FAIL b2b_ready_pulse: got %0d multi-cycle strobes expected 0", pulse_bad); end
        while (busy && drain < 20) begin
            @(posedge clk);
            #1;
            drain++;
        end
        rsp_ready = 2'b00;
    endtask

    task automatic test_backpressure;
        int lat = 0;
        int unstable = 0;
        logic [31:0] d0;
        set_req(0, 2'b00, 16'h0010, 16'h0020, 1'b1);
        set_req(1, 2'b01, 16'd9, 16'd4, 1'b0);
        req_valid = 2'b01;
        #1;
        @(posedge clk);
        #1;
        req_valid = 2'b10;
        while (rsp_valid[0] !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        d0 = rsp_data;
        checks++; if (d0 !== 32'h0000_0031) begin errors++; $display("FAIL bp_data: got %h expected 00000031", d0); end
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid !== 2'b01 || rsp_data !== 32'h0000_0031 || busy !== 1'b1 || req_ready !== 2'b00)
                unstable++;
            @(posedge clk);
            #1;
        end
        checks++; if (unstable !== 0) begin errors++; $display("FAIL bp_stall_stable: got %0d bad cycles expected 0", unstable); end
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[0] = 1'b0;
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL bp_release_valid: got %b expected 00", rsp_valid); end
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_next_grant: got %b expected 10", req_ready); end
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        lat = 0;
        while (rsp_valid[1] !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++; if (rsp_data !== 32'h0000_0005 || rsp_valid !== 2'b10) begin errors++; $display("FAIL bp_req1_rsp: got valid=%b data=%h expected 10/00000005", rsp_valid, rsp_data); end
        rsp_ready[1] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[1] = 1'b0;
    endtask

    task automatic test_reset_mid_wait;
        int lat = 0;
        int spurious = 0;
        set_req(1, 2'b10, 16'h00AA, 16'h0003, 1'b0);
        req_valid = 2'b10;
        #1;
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b expected 0", busy); end
        checks++; if (alu_x !== 16'h0 || alu_y !== 16'h0 || alu_sel !== 2'b00) begin errors++; $display("FAIL mid_reset_alu: got x=%h y=%h sel=%b expected 0/0/00", alu_x, alu_y, alu_sel); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL mid_reset_rsp_data: got %h expected 0", rsp_data); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid !== 2'b00) spurious++;
            @(posedge clk);
            #1;
        end
        checks++; if (spurious !== 0) begin errors++; $display("FAIL mid_reset_no_rsp: got %0d cycles with rsp_valid expected 0", spurious); end
        set_req(0, 2'b00, 16'd2, 16'd3, 1'b0);
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mid_reset_first_grant: got %b expected 01", req_ready); end
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        while (rsp_valid[0] !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++; if (rsp_data !== 32'h0000_0005 || lat !== 3) begin errors++; $display("FAIL mid_reset_txn: got data=%h lat=%0d expected 00000005/3", rsp_data, lat); end
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[0] = 1'b0;
    endtask

    initial begin
        test_reset;
        test_add;
        test_sub_mul;
        test_shift;
        test_back_to_back;
        test_backpressure;
        test_reset_mid_wait;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
